// File: rtl/fifo_status_monitor.sv
// Occupancy, sticky error and watermark flag tracker for the five QoS FIFOs
// (MF, VC0, VC1, D0, D1); all outputs registered one cycle after the strobes.
module fifo_status_monitor #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [5*CW-1:0] umbral_af,
  input  logic [5*CW-1:0] umbral_ae,
  input  logic [4:0]      push,
  input  logic [4:0]      pop,
  output logic [4:0]      fifo_empties,
  output logic [4:0]      fifo_errors,
  output logic [4:0]      almost_full,
  output logic [4:0]      almost_empty,
  output logic [5*CW-1:0] count
);

  localparam int N = 5;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] AF_RST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] AE_RST  = CW'(1);

  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0][CW-1:0] af_q, ae_q;
  logic [N-1:0]         err_d, ne_d, af_d, ae_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = '0;
    ne_d  = '0;
    af_d  = '0;
    ae_d  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      unique case ({push[i], pop[i]})
        2'b10: begin
          if (cnt_q[i] == DEPTH_C) err_d[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + ONE_C;
        end
        2'b01: begin
          if (cnt_q[i] == '0) err_d[i] = 1'b1;
          else                cnt_d[i] = cnt_q[i] - ONE_C;
        end
        2'b11: begin
          // On empty the push lands but the pop underflows.
          if (cnt_q[i] == '0) begin
            cnt_d[i] = ONE_C;
            err_d[i] = 1'b1;
          end
        end
        default: ;
      endcase
      ne_d[i] = (cnt_d[i] != '0);
      af_d[i] = (cnt_d[i] >= af_q[i]);
      ae_d[i] = (cnt_d[i] <= ae_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      af_q         <= {N{AF_RST}};
      ae_q         <= {N{AE_RST}};
      fifo_empties <= '0;
      fifo_errors  <= '0;
      almost_full  <= '0;
      almost_empty <= '1;
    end else begin
      cnt_q        <= cnt_d;
      fifo_empties <= ne_d;
      fifo_errors  <= fifo_errors | err_d;
      almost_full  <= af_d;
      almost_empty <= ae_d;
      if (init) begin
        af_q <= umbral_af;
        ae_q <= umbral_ae;
      end
    end
  end

  assign count = cnt_q;

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Directed plus random stimulus for fifo_status_monitor, checked against an
// integer occupancy model driven by the accept/reject rules of each strobe.
module tb_fifo_status_monitor;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            init = 1'b0;
  logic [5*CW-1:0] umbral_af = '0;
  logic [5*CW-1:0] umbral_ae = '0;
  logic [4:0]      push = '0;
  logic [4:0]      pop = '0;
  logic [4:0]      fifo_empties, fifo_errors, almost_full, almost_empty;
  logic [5*CW-1:0] count;

  fifo_status_monitor #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .push         (push),
    .pop          (pop),
    .fifo_empties (fifo_empties),
    .fifo_errors  (fifo_errors),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_cnt [5];
  int m_af  [5];
  int m_ae  [5];
  bit m_err [5];
  bit m_full[5];
  bit m_aemp[5];

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [4:0] p, input logic [4:0] q, input logic in, input logic rn);
    logic [4:0]  e_ne, e_err, e_af, e_ae;
    logic [19:0] e_cnt;
    push = p; pop = q; init = in; reset = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      for (int i = 0; i < 5; i++) begin
        m_cnt[i] = 0; m_err[i] = 0; m_af[i] = DEPTH - 1; m_ae[i] = 1;
        m_full[i] = 0; m_aemp[i] = 1;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        bit pop_ok, push_ok;
        pop_ok  = q[i] && (m_cnt[i] > 0);
        push_ok = p[i] && (m_cnt[i] < DEPTH || pop_ok);
        if ((q[i] && !pop_ok) || (p[i] && !push_ok)) m_err[i] = 1;
        m_cnt[i]  = m_cnt[i] + int'(push_ok) - int'(pop_ok);
        m_full[i] = (m_cnt[i] >= m_af[i]);
        m_aemp[i] = (m_cnt[i] <= m_ae[i]);
        if (in) begin
          m_af[i] = int'(umbral_af[i*CW +: CW]);
          m_ae[i] = int'(umbral_ae[i*CW +: CW]);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
      e_ne[i]  = (m_cnt[i] != 0);
      e_err[i] = m_err[i];
      e_af[i]  = m_full[i];
      e_ae[i]  = m_aemp[i];
    end
    check("count",        {{(20-5*CW){1'b0}}, count}, e_cnt);
    check("fifo_empties", {15'd0, fifo_empties}, {15'd0, e_ne});
    check("fifo_errors",  {15'd0, fifo_errors},  {15'd0, e_err});
    check("almost_full",  {15'd0, almost_full},  {15'd0, e_af});
    check("almost_empty", {15'd0, almost_empty}, {15'd0, e_ae});
  endtask

  initial begin
    // Reset state
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    // Fill VC0 to DEPTH, then overflow it
    for (int k = 0; k < DEPTH; k++) step(5'b00010, '0, 1'b0, 1'b1);
    step(5'b00010, '0, 1'b0, 1'b1);
    // Fill MF, then simultaneous push+pop on full
    for (int k = 0; k < DEPTH; k++) step(5'b00001, '0, 1'b0, 1'b1);
    step(5'b00001, 5'b00001, 1'b0, 1'b1);
    // Underflow on empty D1; push+pop on empty D0
    step('0, 5'b10000, 1'b0, 1'b1);
    step(5'b01000, 5'b01000, 1'b0, 1'b1);
    // Further traffic keeps errors sticky, reset clears them
    step(5'b00100, 5'b00010, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1);
    // Load MF watermarks af=3 ae=2, then push MF three times
    umbral_af = {4'd7, 4'd7, 4'd7, 4'd7, 4'd3};
    umbral_ae = {4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    step('0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(5'b00001, '0, 1'b0, 1'b1);
    // Edge watermarks: af=0, af>DEPTH, ae>=DEPTH, ae>af
    umbral_af = {4'd15, 4'd0, 4'd9, 4'd2, 4'd0};
    umbral_ae = {4'd8, 4'd15, 4'd5, 4'd0, 4'd12};
    step(5'b11111, '0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(5'b11111, '0, 1'b0, 1'b1);
    // Mid-stream reset, then check watermarks returned to DEPTH-1 / 1
    step(5'b11111, '0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH - 1; k++) step(5'b11111, '0, 1'b0, 1'b1);
    // Randomized traffic with occasional watermark loads and resets
    for (int k = 0; k < 400; k++) begin
      logic [4:0] rp, rq;
      logic ri, rr;
      rp = 5'($urandom);
      rq = 5'($urandom);
      ri = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 79) != 0);
      if (ri) begin
        for (int i = 0; i < 5; i++) begin
          umbral_af[i*CW +: CW] = CW'($urandom_range(0, 15));
          umbral_ae[i*CW +: CW] = CW'($urandom_range(0, 15));
        end
      end
      step(rp, rq, ri, rr);
    end
    // Drain everything
    for (int k = 0; k < DEPTH + 1; k++) step('0, 5'b11111, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
